// File: rtl/seq_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
//   state_e    : controller states
//   len_width  : width of the pattern-length field for a given maximum length
//   clamp_len  : maps a requested length onto the supported range 1..max_len
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  // Zero means a one-bit pattern; anything beyond the register width is cut back to it.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// History shift register, fill counter and length-masked comparator.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   shift_en_i   : shift xin_i into history bit0 this cycle
//   clear_i      : clear history and fill (takes precedence over shift_en_i)
//   xin_i        : serial data bit
//   len_i        : active pattern length (already clamped to 1..PAT_W)
//   pattern_i    : pattern, bit[len-1] oldest
//   hit_o        : the shift happening on the coming edge completes a match
// Build option: SEQ_CTRL_OVERLAP_EN keeps history and fill after a match so a
// match tail can start the next one; otherwise fill restarts on every match.
module seq_shift_match #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             xin_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d;

  // The comparison looks at the post-shift view so hit_o lines up with the accepting edge.
  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], xin_i};
    fill_d = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
    mask   = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len_i));
    end
    hit_o = shift_en_i && (fill_d >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en_i) begin
      hist_q <= hist_d;
`ifdef SEQ_CTRL_OVERLAP_EN
      fill_q <= fill_d;
`else
      fill_q <= hit_o ? '0 : fill_d;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector with controller FSM.
// Software loads pattern/length/target over a valid/ready port, then starts a
// run; each match pulses match_o and bumps match_count_o, and the run ends in
// DONE when a non-zero target is reached. abort returns to IDLE from anywhere.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o   : config handshake (ready in IDLE and DONE)
//   cfg_pattern_i, cfg_len_i    : pattern (bit[len-1] first in time) and length
//   cfg_target_i                : matches that end a run, 0 = unlimited
//   start_i, abort_i            : run control, abort has highest priority
//   xin_i, xin_valid_i          : serial data and its qualifier
//   match_o, match_count_o      : registered match pulse and run match count
//   busy_o, done_o              : in RUN / in DONE
// Build option: SEQ_CTRL_OVERLAP_EN selects overlapping detection (see seq_shift_match).
module seq_detect_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned LEN_W = seq_pkg::len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [CNT_W-1:0] cfg_target_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             xin_i,
  input  logic             xin_valid_i,
  output logic             match_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             match_q, match_d;
  logic             load, clear, shift, hit;

  seq_shift_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_match (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift),
    .clear_i    (clear),
    .xin_i      (xin_i),
    .len_i      (len_q),
    .pattern_i  (pat_q),
    .hit_o      (hit)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    shift   = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_valid_i) begin
            load    = 1'b1;
            state_d = StLoaded;
          end
        end
        StLoaded: begin
          if (start_i) begin
            clear   = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (xin_valid_i) begin
            shift = 1'b1;
            if (hit) begin
              match_d = 1'b1;
              // Saturate only matters for unlimited runs; a target stops the count first.
              if (cnt_q != '1) cnt_d = cnt_inc;
              if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = StDone;
            end
          end
        end
        StDone: begin
          // A completed config handshake wins over start since cfg_ready_o is high here.
          if (cfg_valid_i) begin
            load    = 1'b1;
            state_d = StLoaded;
          end else if (start_i) begin
            clear   = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      match_q <= 1'b0;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      if (load) begin
        pat_q <= cfg_pattern_i;
        len_q <= LEN_W'(clamp_len(int'(32'(cfg_len_i)), PAT_W));
        tgt_q <= cfg_target_i;
      end
    end
  end

  assign cfg_ready_o   = (state_q == StIdle) || (state_q == StDone);
  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign match_o       = match_q;
  assign match_count_o = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 4;
`ifdef SEQ_CTRL_OVERLAP_EN
  localparam int CNT_AFTER_5 = 3;
`else
  localparam int CNT_AFTER_5 = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_valid_i = 1'b0, cfg_ready_o;
  logic [PAT_W-1:0] cfg_pattern_i = '0;
  logic [LEN_W-1:0] cfg_len_i = '0;
  logic [CNT_W-1:0] cfg_target_i = '0;
  logic start_i = 1'b0, abort_i = 1'b0, xin_i = 1'b0, xin_valid_i = 1'b0;
  logic match_o, busy_o, done_o;
  logic [CNT_W-1:0] match_count_o;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_pattern_i (cfg_pattern_i),
    .cfg_len_i     (cfg_len_i),
    .cfg_target_i  (cfg_target_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .xin_i         (xin_i),
    .xin_valid_i   (xin_valid_i),
    .match_o       (match_o),
    .match_count_o (match_count_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 loaded, 2 run, 3 done; bits seen since the
  // run started (or since the last match when detection does not overlap).
  int         m_phase = 0;
  logic [7:0] m_pat = '0;
  int         m_len = 1;
  int         m_tgt = 0;
  int         m_cnt = 0;
  bit         m_q[$];
  logic       exp_match = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt = 0;
    exp_match = 1'b0;
    m_q.delete();
  endtask

  task automatic configure(input logic [7:0] pat, input int len, input int tgt);
    cfg_pattern_i = pat;
    cfg_len_i = len[3:0];
    cfg_target_i = tgt[7:0];
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    exp_match = 1'b0;
    if (m_phase == 0 || m_phase == 3) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > 8) ? 8 : len);
      m_tgt = tgt;
      m_phase = 1;
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    exp_match = 1'b0;
    if (m_phase == 1 || m_phase == 3) begin
      m_phase = 2;
      m_cnt = 0;
      m_q.delete();
    end
  endtask

  // abort is driven together with start/xin_valid to show it overrides them.
  task automatic do_abort();
    abort_i = 1'b1;
    start_i = 1'b1;
    xin_valid_i = 1'b1;
    xin_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    xin_valid_i = 1'b0;
    model_reset();
  endtask

  task automatic drive_bit(input bit b, input bit v);
    bit hit;
    xin_i = b;
    xin_valid_i = v;
    step();
    xin_valid_i = 1'b0;
    exp_match = 1'b0;
    if (m_phase == 2 && v) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++) begin
          if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
      end
      if (hit) begin
        exp_match = 1'b1;
        if (m_cnt < 255) m_cnt++;
`ifndef SEQ_CTRL_OVERLAP_EN
        m_q.delete();
`endif
        if (m_tgt != 0 && m_cnt == m_tgt) m_phase = 3;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({match_o, match_count_o, busy_o, done_o, cfg_ready_o} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got m=%b c=%0d b=%b d=%b r=%b want 0 0 0 0 1",
               match_o, match_count_o, busy_o, done_o, cfg_ready_o);
    end
    #1 reset = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_zeros();
    configure(8'b000, 3, 0);
    do_start();
    for (int i = 1; i <= 6; i++) begin
      drive_bit(1'b0, 1'b1);
      n_tests++;
      if ({match_o, match_count_o, busy_o, done_o} !== {exp_match, 8'(m_cnt), m_phase == 2, m_phase == 3}) begin
        n_fail++;
        $display("FAIL zeros bit %0d: got m=%b c=%0d b=%b d=%b want m=%b c=%0d", i,
                 match_o, match_count_o, busy_o, done_o, exp_match, m_cnt);
      end
      if (i == 5) begin
        n_tests++;
        if (match_count_o !== 8'(CNT_AFTER_5)) begin
          n_fail++;
          $display("FAIL zeros count after 5: got %0d want %0d", match_count_o, CNT_AFTER_5);
        end
      end
    end
    do_abort();
  endtask

  task automatic test_target(input bit gaps);
    bit stream [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    configure(8'b10, 2, 2);
    do_start();
    foreach (stream[i]) begin
      if (gaps) drive_bit(~stream[i], 1'b0);
      drive_bit(stream[i], 1'b1);
      n_tests++;
      if ({match_o, match_count_o, busy_o, done_o} !== {exp_match, 8'(m_cnt), m_phase == 2, m_phase == 3}) begin
        n_fail++;
        $display("FAIL target gaps=%0d bit %0d: got m=%b c=%0d b=%b d=%b want m=%b c=%0d", gaps, i,
                 match_o, match_count_o, busy_o, done_o, exp_match, m_cnt);
      end
    end
    n_tests++;
    if ({match_count_o, busy_o, done_o, cfg_ready_o} !== {8'd2, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL target end gaps=%0d: got c=%0d b=%b d=%b r=%b want 2 0 1 1", gaps,
               match_count_o, busy_o, done_o, cfg_ready_o);
    end
  endtask

  task automatic test_abort();
    configure(8'b11, 2, 0);
    do_start();
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    n_tests++;
    if (match_count_o !== 8'd1) begin
      n_fail++;
      $display("FAIL abort precount: got %0d want 1", match_count_o);
    end
    do_abort();
    n_tests++;
    if ({match_o, match_count_o, busy_o, done_o, cfg_ready_o} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort: got m=%b c=%0d b=%b d=%b r=%b want 0 0 0 0 1",
               match_o, match_count_o, busy_o, done_o, cfg_ready_o);
    end
    do_start();
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    n_tests++;
    if ({match_o, match_count_o, busy_o, cfg_ready_o} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL start in idle: got m=%b c=%0d b=%b r=%b want 0 0 0 1",
               match_o, match_count_o, busy_o, cfg_ready_o);
    end
  endtask

  task automatic test_async_reset();
    configure(8'b1, 1, 0);
    do_start();
    drive_bit(1'b1, 1'b1);
    n_tests++;
    if ({match_o, match_count_o, busy_o} !== {1'b1, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL pre-reset: got m=%b c=%0d b=%b want 1 1 1", match_o, match_count_o, busy_o);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({match_o, match_count_o, busy_o, done_o, cfg_ready_o} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async reset: got m=%b c=%0d b=%b d=%b r=%b want 0 0 0 0 1",
               match_o, match_count_o, busy_o, done_o, cfg_ready_o);
    end
    #1 reset = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_len_clamp();
    logic [7:0] pat;
    bit b;
    configure(8'b1, 0, 0);
    do_start();
    for (int i = 0; i < 16; i++) begin
      drive_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      n_tests++;
      if ({match_o, match_count_o, busy_o, done_o} !== {exp_match, 8'(m_cnt), m_phase == 2, m_phase == 3}) begin
        n_fail++;
        $display("FAIL len0 bit %0d: got m=%b c=%0d want m=%b c=%0d", i,
                 match_o, match_count_o, exp_match, m_cnt);
      end
    end
    do_abort();
    pat = 8'($urandom);
    configure(pat, 12, 0);
    do_start();
    for (int i = 0; i < 26; i++) begin
      b = (i >= 10 && i < 18) ? pat[17 - i] : 1'($urandom_range(0, 1));
      drive_bit(b, 1'b1);
      n_tests++;
      if ({match_o, match_count_o, busy_o, done_o} !== {exp_match, 8'(m_cnt), m_phase == 2, m_phase == 3}) begin
        n_fail++;
        $display("FAIL len12 bit %0d: got m=%b c=%0d want m=%b c=%0d", i,
                 match_o, match_count_o, exp_match, m_cnt);
      end
    end
    n_tests++;
    if (match_count_o < 8'd1) begin
      n_fail++;
      $display("FAIL len12 embedded pattern: got count %0d want >=1", match_count_o);
    end
    do_abort();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      configure(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      do_start();
      for (int i = 0; i < 60; i++) begin
        drive_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        n_tests++;
        if ({match_o, match_count_o, busy_o, done_o} !== {exp_match, 8'(m_cnt), m_phase == 2, m_phase == 3}) begin
          n_fail++;
          $display("FAIL random run %0d bit %0d: got m=%b c=%0d b=%b d=%b want m=%b c=%0d b=%b d=%b",
                   r, i, match_o, match_count_o, busy_o, done_o, exp_match, m_cnt,
                   m_phase == 2, m_phase == 3);
        end
        if (m_phase == 3 && $urandom_range(0, 1) == 1) begin
          do_start();
          n_tests++;
          if ({match_count_o, busy_o, done_o} !== {8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart run %0d: got c=%0d b=%b d=%b want 0 1 0", r,
                     match_count_o, busy_o, done_o);
          end
        end
      end
      if (m_phase != 3) do_abort();
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_target(1'b0);
    test_target(1'b1);
    test_abort();
    test_async_reset();
    test_len_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
